alu_sequencer: RTL and testbench
================================

// Module: alu_sequencer
// PURPOSE
//   Controller for the 32x32 register file + 4-op ALU datapath (ADD/SUB/SHL/SHR).
//   - Accepts one instruction at a time on a valid/ready handshake.
//   - Sequences the regfile read, the ALU execute and the write-back to rd.
//   - Supports a load-immediate path that writes in_imm straight to rd.
//   - Sits between the instruction source and the regfile/ALU pair in the top-level wrapper.
// PARAMETERS
//   ADDR_W  5   register address width (32 registers)
//   DATA_W  32  datapath width
//   PERF_W  16  retired-instruction counter width (only with ALU_SEQ_PERF_CNT_EN)
// PORTS
//   clock      in   1       single clock; all state updates on posedge
//   reset      in   1       asynchronous, active-high
//   in_valid   in   1       instruction offered
//   in_ready   out  1       sequencer idle, can accept
//   in_load    in   1       1 = load immediate, 0 = ALU op
//   in_op      in   2       ALU op: 00 ADD, 01 SUB, 10 SHL, 11 SHR
//   in_rd      in   ADDR_W  destination register
//   in_rs1     in   ADDR_W  source a
//   in_rs2     in   ADDR_W  source b
//   in_imm     in   DATA_W  immediate for load
//   rf_we      out  1       regfile write enable (regfile reads only when rf_we=0)
//   rf_a1      out  ADDR_W  regfile read address 1
//   rf_a2      out  ADDR_W  regfile read address 2
//   rf_a3      out  ADDR_W  regfile write address
//   rf_wd      out  DATA_W  regfile write data
//   alu_op     out  2       ALU opcode
//   alu_result in   DATA_W  registered ALU output
//   done_valid out  1       one-cycle pulse, write-back occurring this cycle
//   done_rd    out  ADDR_W  register written
//   done_data  out  DATA_W  value written
//   perf_count out  PERF_W  retired instructions (port exists only with ALU_SEQ_PERF_CNT_EN)
// BEHAVIOUR
//   State machine: IDLE, READ, EXEC, WRITE.
//   - IDLE: in_ready=1. On in_valid, capture load/op/rd/rs1/rs2/imm into holding registers.
//     load=1 goes to WRITE; load=0 goes to READ.
//   - READ: rf_we=0; rf_a1/rf_a2 = captured rs1/rs2; regfile latches RD1/RD2 at the cycle end. Goes to EXEC.
//   - EXEC: rf_we=0; alu_op = captured op; ALU latches the result at the cycle end. Goes to WRITE.
//   - WRITE: rf_we=1; rf_a3=rd; rf_wd = alu_result (ALU op) or imm (load).
//     done_valid=1, done_rd=rd, done_data=rf_wd. Goes to IDLE.
//   Latency, counted from the accept cycle T:
//   - ALU op writes in T+3, next accept possible at T+4.
//   - Load writes in T+1, next accept possible at T+2.
//   Output timing and hold:
//   - All rf_*, alu_op and done_* outputs are driven from holding registers and state only.
//   - No combinational path exists from in_* to any rf_*, alu_op or done_* output.
//   - alu_op and rf_a1/rf_a2 hold their captured values outside READ/EXEC. The ALU clocks every cycle, so its result stays stable.
//   Inputs and hazards:
//   - in_* is ignored when in_ready=0; the source holds its offer until accepted.
//   - rd == rs1 or rd == rs2 is legal: sources are read in READ, before the WRITE cycle.
//   - rd = 0 is an ordinary register; no hardwired zero.
//   Arithmetic belongs to the ALU: 32-bit wrap on ADD/SUB; SHL/SHR are logical and shift by the full 32-bit b (b>=32 gives 0).
//   Reset values: state=IDLE, in_ready=0 while reset is high, and every other output and holding register = 0.
//   Reset mid-operation: an in-flight instruction is aborted, with no write and no done pulse.
//   - rf_we drops asynchronously.
//   - in_ready returns to 1 on the first clock after reset deasserts.
// CONFIGURATION
//   ALU_SEQ_PERF_CNT_EN defined:
//   - perf_count exists; it increments by 1 on every WRITE cycle and wraps at 2^PERF_W.
//   - It resets to 0.
//   ALU_SEQ_PERF_CNT_EN undefined: no perf_count port and no counter logic; behaviour is otherwise identical.
// STRUCTURE
//   Package alu_seq_pkg holds:
//   - the state enum (IDLE/READ/EXEC/WRITE, 2-bit encoding);
//   - op localparams OP_ADD=2'b00, OP_SUB=2'b01, OP_SHL=2'b10, OP_SHR=2'b11;
//   - the ADDR_W/DATA_W defaults.
//   No sub-module: FSM, holding registers and the optional counter are flat.
//   Regfile and ALU are instantiated beside this block in the wrapper, not inside it.
// TESTING
//   Bench = wrapper with alu_sequencer + regfile + ALU.
//   1. Load r1=5, r2=3, then ADD r3=r1+r2 -> done_valid in T+3, done_rd=3, done_data=8, and in_ready low T+1..T+3.
//   2. SUB r4=r2-r1 (3-5) -> done_data=32'hFFFF_FFFE.
//      Then SHL r5=r1<<r2 -> 40; SHR r6=r5>>r2 -> 5.
//   3. Load r7=32 and SHL r8=r1<<r7 -> done_data=0.
//      ADD r1=r1+r1 (rd aliases rs) -> done_data=10.
//   4. Hold in_valid high continuously with a stream of ALU ops -> exactly one accept every 4 cycles.
//      Mixed with loads -> load accepts every 2 cycles.
//   5. Assert reset during EXEC of ADD r9=r1+r2 -> rf_we never rises and no done pulse.
//      Afterwards r9 still reads its old value and in_ready=1 one clock after reset deasserts.
//   6. With ALU_SEQ_PERF_CNT_EN: 6 instructions -> perf_count=6, and reset clears it to 0.
//      Build without the macro also passes tests 1-5.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU sequencer: FSM state encoding, ALU opcodes
// and default datapath widths.
package alu_seq_pkg;

   localparam int ADDR_W_DEF = 5;
   localparam int DATA_W_DEF = 32;

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_SHL = 2'b10;
   localparam logic [1:0] OP_SHR = 2'b11;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      READ  = 2'b01,
      EXEC  = 2'b10,
      WRITE = 2'b11
   } state_t;

endpackage

// File: rtl/alu_sequencer.sv
// alu_sequencer: sequences one instruction at a time through an external
// register file and registered 4-op ALU (read, execute, write-back), or
// writes an immediate straight to rd for loads.
//
// Optional feature: define ALU_SEQ_PERF_CNT_EN to add the perf_count port
// (retired-instruction counter, PERF_W bits, wraps).
//
// Ports:
//   clock, reset           single clock, async active-high reset
//   in_valid / in_ready    instruction handshake
//   in_load, in_op, in_rd, in_rs1, in_rs2, in_imm   instruction fields
//   rf_we, rf_a1..rf_a3, rf_wd                      regfile control
//   alu_op, alu_result                              ALU control / result
//   done_valid, done_rd, done_data                  write-back report
//   perf_count                                      (ALU_SEQ_PERF_CNT_EN only)
//
// state | meaning
// IDLE  | ready for a new instruction
// READ  | regfile reads rs1/rs2
// EXEC  | ALU computes captured op
// WRITE | write-back to rd, done pulse
module alu_sequencer
   import alu_seq_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
`ifdef ALU_SEQ_PERF_CNT_EN
   parameter int PERF_W = 16,
`endif
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              in_load,
   input  logic [1:0]        in_op,
   input  logic [ADDR_W-1:0] in_rd,
   input  logic [ADDR_W-1:0] in_rs1,
   input  logic [ADDR_W-1:0] in_rs2,
   input  logic [DATA_W-1:0] in_imm,
   output logic              rf_we,
   output logic [ADDR_W-1:0] rf_a1,
   output logic [ADDR_W-1:0] rf_a2,
   output logic [ADDR_W-1:0] rf_a3,
   output logic [DATA_W-1:0] rf_wd,
   output logic [1:0]        alu_op,
   input  logic [DATA_W-1:0] alu_result,
   output logic              done_valid,
   output logic [ADDR_W-1:0] done_rd,
   output logic [DATA_W-1:0] done_data
`ifdef ALU_SEQ_PERF_CNT_EN
   ,
   output logic [PERF_W-1:0] perf_count
`endif
);

   state_t            state, state_nxt;
   logic              armed;
   logic              accept;
   logic              in_write;
   logic              load_q;
   logic [1:0]        op_q;
   logic [ADDR_W-1:0] rd_q, rs1_q, rs2_q;
   logic [DATA_W-1:0] imm_q;

   // armed keeps in_ready low until the first clock after reset releases
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         armed <= 1'b0;
      end else begin
         state <= state_nxt;
         armed <= 1'b1;
      end
   end

   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      in_write  = 1'b0;
      case (state)
         IDLE: begin
            if (in_valid && armed) begin
               accept    = 1'b1;
               state_nxt = in_load ? WRITE : READ;
            end
         end
         READ:  state_nxt = EXEC;
         EXEC:  state_nxt = WRITE;
         WRITE: begin
            in_write  = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         load_q <= 1'b0;
         op_q   <= '0;
         rd_q   <= '0;
         rs1_q  <= '0;
         rs2_q  <= '0;
         imm_q  <= '0;
      end else if (accept) begin
         load_q <= in_load;
         op_q   <= in_op;
         rd_q   <= in_rd;
         rs1_q  <= in_rs1;
         rs2_q  <= in_rs2;
         imm_q  <= in_imm;
      end
   end

   // Everything below comes from state and holding registers; in_* never
   // reaches the regfile/ALU side combinationally. rf_we follows the async
   // state reset, so it drops immediately when reset rises.
   assign in_ready   = armed && (state == IDLE);
   assign rf_we      = in_write;
   assign rf_a1      = rs1_q;
   assign rf_a2      = rs2_q;
   assign rf_a3      = rd_q;
   assign alu_op     = op_q;
   assign rf_wd      = in_write ? (load_q ? imm_q : alu_result) : '0;
   assign done_valid = in_write;
   assign done_rd    = rd_q;
   assign done_data  = rf_wd;

`ifdef ALU_SEQ_PERF_CNT_EN
   logic [PERF_W-1:0] perf_q;

   always_ff @(posedge clock or posedge reset) begin
      if (reset)
         perf_q <= '0;
      else if (in_write)
         perf_q <= perf_q + PERF_W'(1);
   end

   assign perf_count = perf_q;
`endif

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench: alu_sequencer plus behavioural regfile and registered ALU, with an
// architectural model (register array + expected write-back queue) checked
// every cycle, and literal expectations for the directed scenarios.
module tb_alu_sequencer;
   import alu_seq_pkg::*;

   localparam int AW = 5;
   localparam int DW = 32;

   logic          clock = 1'b0;
   logic          reset = 1'b1;
   logic          in_valid = 1'b0, in_ready, in_load = 1'b0;
   logic [1:0]    in_op = '0;
   logic [AW-1:0] in_rd = '0, in_rs1 = '0, in_rs2 = '0;
   logic [DW-1:0] in_imm = '0;
   logic          rf_we, done_valid;
   logic [AW-1:0] rf_a1, rf_a2, rf_a3, done_rd;
   logic [DW-1:0] rf_wd, done_data, alu_res;
   logic [1:0]    alu_op;
`ifdef ALU_SEQ_PERF_CNT_EN
   logic [15:0]   perf_count;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   alu_sequencer dut (
      .clock(clock), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready), .in_load(in_load), .in_op(in_op),
      .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
      .rf_we(rf_we), .rf_a1(rf_a1), .rf_a2(rf_a2), .rf_a3(rf_a3), .rf_wd(rf_wd),
      .alu_op(alu_op), .alu_result(alu_res),
      .done_valid(done_valid), .done_rd(done_rd), .done_data(done_data)
`ifdef ALU_SEQ_PERF_CNT_EN
      , .perf_count(perf_count)
`endif
   );

   always #5 clock = ~clock;

   function automatic logic [DW-1:0] alu_f(logic [DW-1:0] a, logic [DW-1:0] b, logic [1:0] op);
      case (op)
         OP_ADD:  return a + b;
         OP_SUB:  return a - b;
         OP_SHL:  return (b >= 32) ? '0 : (a << b[4:0]);
         default: return (b >= 32) ? '0 : (a >> b[4:0]);
      endcase
   endfunction

   // Wrapper-side regfile (not reset) and ALU (clocks every cycle)
   logic [DW-1:0] regs [32];
   logic [DW-1:0] rd1, rd2;
   initial begin
      for (int i = 0; i < 32; i++) regs[i] = '0;
      rd1 = '0;
      rd2 = '0;
      alu_res = '0;
   end
   always @(posedge clock) begin
      if (rf_we) regs[rf_a3] <= rf_wd;
      else begin
         rd1 <= regs[rf_a1];
         rd2 <= regs[rf_a2];
      end
      alu_res <= alu_f(rd1, rd2, alu_op);
   end

   task automatic chk(string name, logic [63:0] got, logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, got, exp);
      end
   endtask

   // ---------------- architectural model ----------------
   typedef struct {
      int            due;
      logic [AW-1:0] rd;
      logic [DW-1:0] data;
   } exp_t;

   exp_t          q[$];
   int            acc_q[$];
   logic [DW-1:0] arch [32];
   int            cyc = 0;
   int            next_free = 0;
   bit            armed_m = 1'b0;
   logic [AW-1:0] cap_rs1 = '0, cap_rs2 = '0, cap_rd = '0;
   logic [1:0]    cap_op = '0;
   logic [15:0]   perf_m = '0;

   initial for (int i = 0; i < 32; i++) arch[i] = '0;

   always @(negedge clock) begin
      if (reset) begin
         chk("rst_in_ready", in_ready, 0);
         chk("rst_rf_we", rf_we, 0);
         chk("rst_done_valid", done_valid, 0);
         chk("rst_addrs", {rf_a1, rf_a2, rf_a3, done_rd, alu_op}, 0);
         chk("rst_data", {rf_wd, done_data}, 0);
         q.delete();
         armed_m   = 1'b0;
         next_free = 0;
         cap_rs1 = '0; cap_rs2 = '0; cap_rd = '0; cap_op = '0;
         perf_m  = '0;
      end else begin
         bit ready_exp, wb_exp;
         ready_exp = armed_m && (cyc >= next_free);
         wb_exp    = (q.size() > 0) && (q[0].due == cyc);
         chk("in_ready", in_ready, ready_exp);
         chk("rf_we", rf_we, wb_exp);
         chk("done_valid", done_valid, wb_exp);
         chk("rf_a1_hold", rf_a1, cap_rs1);
         chk("rf_a2_hold", rf_a2, cap_rs2);
         chk("alu_op_hold", alu_op, cap_op);
         chk("rf_a3", rf_a3, cap_rd);
`ifdef ALU_SEQ_PERF_CNT_EN
         chk("perf_count", perf_count, perf_m);
`endif
         if (wb_exp) begin
            chk("done_rd", done_rd, q[0].rd);
            chk("done_data", done_data, q[0].data);
            chk("rf_wd", rf_wd, q[0].data);
            arch[q[0].rd] = q[0].data;
            perf_m = perf_m + 16'd1;
            void'(q.pop_front());
         end
         if (ready_exp && in_valid) begin
            exp_t e;
            e.rd   = in_rd;
            e.data = in_load ? in_imm : alu_f(arch[in_rs1], arch[in_rs2], in_op);
            e.due  = cyc + (in_load ? 1 : 3);
            q.push_back(e);
            next_free = cyc + (in_load ? 2 : 4);
            cap_rs1 = in_rs1; cap_rs2 = in_rs2; cap_rd = in_rd; cap_op = in_op;
            acc_q.push_back(cyc);
         end
         armed_m = 1'b1;
      end
      cyc++;
   end

   // ---------------- driver ----------------
   task automatic issue(bit ld, logic [1:0] op, logic [AW-1:0] rd, logic [AW-1:0] rs1,
                        logic [AW-1:0] rs2, logic [DW-1:0] imm);
      in_load = ld; in_op = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
      in_valid = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clock);
         if (in_ready) begin
            @(posedge clock);
            #1;
            in_valid = 1'b0;
            return;
         end
      end
      n_tests++;
      n_fail++;
      $display("FAIL issue_timeout: in_ready not seen for rd=%0d", rd);
      in_valid = 1'b0;
   endtask

   task automatic wait_done(string name, logic [AW-1:0] rd, logic [DW-1:0] data);
      for (int i = 0; i < 12; i++) begin
         @(negedge clock);
         if (done_valid) begin
            chk({name, "_rd"}, done_rd, rd);
            chk(name, done_data, data);
            @(posedge clock);
            #1;
            return;
         end
      end
      n_tests++;
      n_fail++;
      $display("FAIL %s_timeout: no done_valid, expected rd=%0d data=%0h", name, rd, data);
   endtask

   task automatic idle(int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic check_ready_after_reset();
      @(negedge clock);
      chk("ready_low_after_rst", in_ready, 0);
      @(negedge clock);
      chk("ready_one_clk_after_rst", in_ready, 1);
      @(posedge clock);
      #1;
   endtask

   initial begin
      int base;
      repeat (3) @(posedge clock);
      #1 reset = 1'b0;
      check_ready_after_reset();

      issue(1, OP_ADD, 1, 0, 0, 32'd5);  wait_done("ld_r1", 1, 32'd5);
      issue(1, OP_ADD, 2, 0, 0, 32'd3);  wait_done("ld_r2", 2, 32'd3);
      issue(0, OP_ADD, 3, 1, 2, 0);      wait_done("add_r3", 3, 32'd8);
      issue(0, OP_SUB, 4, 2, 1, 0);      wait_done("sub_r4", 4, 32'hFFFF_FFFE);
      issue(0, OP_SHL, 5, 1, 2, 0);      wait_done("shl_r5", 5, 32'd40);
      issue(0, OP_SHR, 6, 5, 2, 0);      wait_done("shr_r6", 6, 32'd5);
      issue(1, OP_ADD, 7, 0, 0, 32'd32); wait_done("ld_r7", 7, 32'd32);
      issue(0, OP_SHL, 8, 1, 7, 0);      wait_done("shl32_r8", 8, 32'd0);
      issue(0, OP_ADD, 1, 1, 1, 0);      wait_done("alias_r1", 1, 32'd10);
      issue(1, OP_ADD, 9, 0, 0, 32'd77); wait_done("ld_r9", 9, 32'd77);

      // back-to-back ALU ops with in_valid held high
      base = acc_q.size();
      issue(0, OP_ADD, 11, 3, 2, 0);
      issue(0, OP_SUB, 12, 3, 2, 0);
      issue(0, OP_SHL, 13, 2, 2, 0);
      issue(0, OP_SHR, 14, 3, 2, 0);
      issue(0, OP_ADD, 15, 1, 1, 0);
      idle(5);
      for (int i = 1; i < 5; i++) chk("alu_stream_gap", acc_q[base+i] - acc_q[base+i-1], 4);

      // back-to-back loads
      base = acc_q.size();
      issue(1, OP_ADD, 16, 0, 0, 32'hDEAD_BEEF);
      issue(1, OP_ADD, 17, 0, 0, 32'h1);
      issue(0, OP_ADD, 18, 16, 17, 0);
      issue(1, OP_ADD, 19, 0, 0, 32'h0);
      issue(1, OP_ADD, 20, 0, 0, 32'h7);
      idle(3);
      chk("load_gap_a", acc_q[base+1] - acc_q[base], 2);
      chk("load_then_alu_gap", acc_q[base+2] - acc_q[base+1], 2);
      chk("alu_then_load_gap", acc_q[base+3] - acc_q[base+2], 4);
      chk("load_gap_b", acc_q[base+4] - acc_q[base+3], 2);
      issue(0, OP_ADD, 21, 18, 0, 0); wait_done("stream_result", 21, 32'hDEAD_BEF0);

      // reset during a WRITE cycle: rf_we must fall without a clock
      issue(1, OP_ADD, 31, 0, 0, 32'h0);
      #1 chk("we_in_write", rf_we, 1);
      reset = 1'b1;
      #1 chk("we_async_drop", rf_we, 0);
      chk("done_async_drop", done_valid, 0);
      @(posedge clock);
      #1 reset = 1'b0;
      check_ready_after_reset();

      // reset during EXEC of ADD r9=r1+r2: r9 must keep 77
      issue(0, OP_ADD, 9, 1, 2, 0);
      idle(1);
      reset = 1'b1;
      idle(2);
      reset = 1'b0;
      check_ready_after_reset();
      issue(0, OP_ADD, 10, 9, 9, 0); wait_done("r9_kept", 10, 32'd154);

`ifdef ALU_SEQ_PERF_CNT_EN
      reset = 1'b1;
      idle(1);
      reset = 1'b0;
      issue(1, OP_ADD, 22, 0, 0, 32'd4);
      issue(1, OP_ADD, 23, 0, 0, 32'd2);
      issue(0, OP_ADD, 24, 22, 23, 0);
      issue(0, OP_SUB, 25, 22, 23, 0);
      issue(0, OP_SHL, 26, 22, 23, 0);
      issue(0, OP_SHR, 27, 22, 23, 0);
      idle(5);
      chk("perf_6", perf_count, 6);
      reset = 1'b1;
      #1 chk("perf_rst", perf_count, 0);
      idle(1);
      reset = 1'b0;
      idle(2);
`endif

      idle(2);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

endmodule
